// File: rtl/tx_arb_pkg.sv
// Shared state encoding, source selects and default tags for the TX response arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    B0   = 2'd2,
    B1   = 2'd3
  } arb_state_e;

  localparam logic SRC_RF  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

  localparam logic [7:0] RF_TAG_DEFAULT  = 8'hA5;
  localparam logic [7:0] ALU_TAG_DEFAULT = 8'h5A;

endpackage

// File: rtl/resp_slot.sv
// One-entry response holding register: captures when empty or releasing this cycle,
// otherwise drops the new data and raises a sticky overflow flag.
module resp_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             release_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pending_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             pending_q, pending_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    data_d    = data_q;
    pending_d = pending_q & ~release_i;
    ovf_d     = ovf_q;
    if (valid_i) begin
      if (!pending_q || release_i) begin
        data_d    = data_i;
        pending_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data_o    = data_q;
  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter serializing RegFile (1-byte) and ALU (2-byte) responses into TX FIFO writes.
// Define RESP_HEADER_EN to prefix every frame with RF_TAG / ALU_TAG.
module tx_resp_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RF_TAG     = DATA_WIDTH'(RF_TAG_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] ALU_TAG    = DATA_WIDTH'(ALU_TAG_DEFAULT)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  input  logic                    RF_VALID,
  output logic                    RF_RDY,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  input  logic                    ALU_VALID,
  output logic                    ALU_RDY,
  input  logic                    FIFO_FULL,
  output logic                    FIFO_WR,
  output logic [DATA_WIDTH-1:0]   TX_DATA_OUT,
  output logic [1:0]              OVF,
  output logic                    BUSY
);

  localparam int unsigned ALU_W = 2 * DATA_WIDTH;

`ifdef RESP_HEADER_EN
  localparam arb_state_e FIRST_ST = HDR;
`else
  localparam arb_state_e FIRST_ST = B0;
  logic unused_tags;
  assign unused_tags = ^{RF_TAG, ALU_TAG};
`endif

  arb_state_e            state_q;
  logic                  last_grant_q;
  logic [DATA_WIDTH-1:0] rf_data;
  logic [ALU_W-1:0]      alu_data;
  logic                  rf_pend, alu_pend;
  logic                  rf_ovf, alu_ovf;
  logic                  rf_release, alu_release;
  logic [DATA_WIDTH-1:0] tx_data_c;

  resp_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
    .clk       (CLK),
    .rst_n     (RST),
    .valid_i   (RF_VALID),
    .data_i    (RF_DATA),
    .release_i (rf_release),
    .data_o    (rf_data),
    .pending_o (rf_pend),
    .ovf_o     (rf_ovf)
  );

  resp_slot #(.WIDTH(ALU_W)) u_alu_slot (
    .clk       (CLK),
    .rst_n     (RST),
    .valid_i   (ALU_VALID),
    .data_i    (ALU_DATA),
    .release_i (alu_release),
    .data_o    (alu_data),
    .pending_o (alu_pend),
    .ovf_o     (alu_ovf)
  );

  // A write is only ever issued while a frame is active and the FIFO has room.
  assign FIFO_WR     = (state_q != IDLE) & ~FIFO_FULL;
  assign rf_release  = FIFO_WR & (state_q == B0) & (last_grant_q == SRC_RF);
  assign alu_release = FIFO_WR & (state_q == B1);

  // last_grant_q doubles as the owner of the frame currently being sent.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_ALU;
    end else begin
      case (state_q)
        IDLE: begin
          if (rf_pend | alu_pend) begin
            if (rf_pend & alu_pend) last_grant_q <= ~last_grant_q;
            else                    last_grant_q <= rf_pend ? SRC_RF : SRC_ALU;
            state_q <= FIRST_ST;
          end
        end
        HDR:     if (FIFO_WR) state_q <= B0;
        B0:      if (FIFO_WR) state_q <= (last_grant_q == SRC_RF) ? IDLE : B1;
        B1:      if (FIFO_WR) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data_c = '0;
    case (state_q)
`ifdef RESP_HEADER_EN
      HDR:     tx_data_c = (last_grant_q == SRC_RF) ? RF_TAG : ALU_TAG;
`endif
      B0:      tx_data_c = (last_grant_q == SRC_RF) ? rf_data : alu_data[DATA_WIDTH-1:0];
      B1:      tx_data_c = alu_data[ALU_W-1:DATA_WIDTH];
      default: tx_data_c = '0;
    endcase
  end

  assign TX_DATA_OUT = tx_data_c;
  assign RF_RDY      = ~rf_pend;
  assign ALU_RDY     = ~alu_pend;
  assign OVF         = {alu_ovf, rf_ovf};
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Self-checking bench for tx_resp_arbiter: vector table, directed corner sequences, random vs frame model.
module tb_tx_resp_arbiter;
  import tx_arb_pkg::*;

`ifdef RESP_HEADER_EN
  localparam int HN = 1;
`else
  localparam int HN = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RF_DATA = '0;
  logic        RF_VALID = 1'b0;
  logic        RF_RDY;
  logic [15:0] ALU_DATA = '0;
  logic        ALU_VALID = 1'b0;
  logic        ALU_RDY;
  logic        FIFO_FULL = 1'b0;
  logic        FIFO_WR;
  logic [7:0]  TX_DATA_OUT;
  logic [1:0]  OVF;
  logic        BUSY;

  tx_resp_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_DATA(RF_DATA), .RF_VALID(RF_VALID), .RF_RDY(RF_RDY),
    .ALU_DATA(ALU_DATA), .ALU_VALID(ALU_VALID), .ALU_RDY(ALU_RDY),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR(FIFO_WR), .TX_DATA_OUT(TX_DATA_OUT),
    .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Every FIFO write, with the cycle it happened in.
  logic [7:0] wq[$];
  int         wt[$];
  logic [7:0] eq[$];
  always @(negedge CLK) if (RST && FIFO_WR) begin
    wq.push_back(TX_DATA_OUT);
    wt.push_back(cyc);
  end

  typedef struct packed {
    logic        is_alu;
    logic [15:0] data;
    logic [1:0]  n;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[4];

  // Behavioural model: per-source slot plus the remaining bytes of the current frame.
  logic       m_rf_p, m_alu_p, m_last, m_cur;
  logic [7:0] m_rf_d;
  logic [15:0] m_alu_d;
  logic [1:0] m_ovf;
  logic [7:0] m_frame[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clrq();
    wq.delete();
    wt.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0; RF_VALID = 1'b0; ALU_VALID = 1'b0; FIFO_FULL = 1'b0;
    steps(2);
    RST = 1'b1;
    clrq();
  endtask

  task automatic pulse(input logic rf, input logic alu, input logic [7:0] rd, input logic [15:0] ad);
    RF_VALID = rf; ALU_VALID = alu; RF_DATA = rd; ALU_DATA = ad;
    step();
    RF_VALID = 1'b0; ALU_VALID = 1'b0;
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), wq[i], eq[i]);
  endtask

  task automatic model_step();
    logic busy, wr, rel_rf, rel_alu;
    busy = (m_frame.size() != 0);
    wr = busy && !FIFO_FULL;
    rel_rf = 1'b0; rel_alu = 1'b0;
    if (wr) begin
      if (m_frame.size() == 1) begin
        if (m_cur == SRC_RF) rel_rf = 1'b1;
        else                 rel_alu = 1'b1;
      end
      void'(m_frame.pop_front());
    end else if (!busy && (m_rf_p || m_alu_p)) begin
      m_cur = (m_rf_p && m_alu_p) ? ~m_last : (m_rf_p ? SRC_RF : SRC_ALU);
      m_last = m_cur;
      if (HN == 1) m_frame.push_back((m_cur == SRC_RF) ? 8'hA5 : 8'h5A);
      if (m_cur == SRC_RF) m_frame.push_back(m_rf_d);
      else begin
        m_frame.push_back(m_alu_d[7:0]);
        m_frame.push_back(m_alu_d[15:8]);
      end
    end
    if (rel_rf) m_rf_p = 1'b0;
    if (rel_alu) m_alu_p = 1'b0;
    if (RF_VALID) begin
      if (!m_rf_p || rel_rf) begin m_rf_d = RF_DATA; m_rf_p = 1'b1; end
      else m_ovf[0] = 1'b1;
    end
    if (ALU_VALID) begin
      if (!m_alu_p || rel_alu) begin m_alu_d = ALU_DATA; m_alu_p = 1'b1; end
      else m_ovf[1] = 1'b1;
    end
  endtask

  initial begin
    int t0;
`ifdef RESP_HEADER_EN
    vecs[0] = '{1'b0, 16'h003C, 2'd2, 24'h003CA5};
    vecs[1] = '{1'b1, 16'hBEEF, 2'd3, 24'hBEEF5A};
    vecs[2] = '{1'b0, 16'h0000, 2'd2, 24'h0000A5};
    vecs[3] = '{1'b1, 16'h8001, 2'd3, 24'h80015A};
`else
    vecs[0] = '{1'b0, 16'h003C, 2'd1, 24'h00003C};
    vecs[1] = '{1'b1, 16'hBEEF, 2'd2, 24'h00BEEF};
    vecs[2] = '{1'b0, 16'h0000, 2'd1, 24'h000000};
    vecs[3] = '{1'b1, 16'h8001, 2'd2, 24'h008001};
`endif

    // Reset values
    @(negedge CLK);
    chk("rst_wr", FIFO_WR, 0);
    chk("rst_tx", TX_DATA_OUT, 0);
    chk("rst_rf_rdy", RF_RDY, 1);
    chk("rst_alu_rdy", ALU_RDY, 1);
    chk("rst_ovf", OVF, 0);
    chk("rst_busy", BUSY, 0);
    do_reset();

    // Single-frame vectors: content, latency, back-to-back bytes, slot freed
    for (int v = 0; v < 4; v++) begin
      t0 = cyc;
      pulse(~vecs[v].is_alu, vecs[v].is_alu, vecs[v].data[7:0], vecs[v].data);
      steps(7);
      chk($sformatf("vec%0d_len", v), wq.size(), 32'(vecs[v].n));
      for (int i = 0; i < int'(vecs[v].n) && i < wq.size(); i++) begin
        chk($sformatf("vec%0d_b%0d", v, i), wq[i], vecs[v].exp[8*i +: 8]);
        chk($sformatf("vec%0d_t%0d", v, i), wt[i] - t0, 2 + i);
      end
      chk($sformatf("vec%0d_rdy", v), vecs[v].is_alu ? ALU_RDY : RF_RDY, 1);
      clrq();
    end

    // Tie after reset: RF first, one idle cycle between frames
    do_reset();
    pulse(1, 1, 8'h11, 16'h2233);
    steps(10);
    if (HN == 1) eq = '{8'hA5, 8'h11, 8'h5A, 8'h33, 8'h22};
    else         eq = '{8'h11, 8'h33, 8'h22};
    chk_seq("tie_rf_first");
    if (wt.size() > HN + 1) chk("tie_gap", wt[HN+1] - wt[HN], 2);
    // After a lone RF frame the tie goes to ALU
    pulse(1, 0, 8'h66, 16'h0);
    steps(6);
    clrq();
    pulse(1, 1, 8'h11, 16'h2233);
    steps(10);
    if (HN == 1) eq = '{8'h5A, 8'h33, 8'h22, 8'hA5, 8'h11};
    else         eq = '{8'h33, 8'h22, 8'h11};
    chk_seq("tie_alu_first");
    clrq();

    // FIFO_FULL for 5 cycles during B1
    t0 = cyc;
    pulse(0, 1, 8'h0, 16'h1234);
    steps(2 + HN);
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_wr", FIFO_WR, 0);
      chk("stall_tx", TX_DATA_OUT, 8'h12);
      chk("stall_busy", BUSY, 1);
      step();
    end
    FIFO_FULL = 1'b0;
    steps(4);
    if (HN == 1) eq = '{8'h5A, 8'h34, 8'h12};
    else         eq = '{8'h34, 8'h12};
    chk_seq("stall");
    if (wt.size() > 0) chk("stall_time", wt[wt.size()-1] - t0, 8 + HN);
    chk("stall_rdy", ALU_RDY, 1);

    // Overflow drop, sticky, and accept in the release cycle
    do_reset();
    pulse(1, 0, 8'h3C, 16'h0);
    pulse(1, 0, 8'h77, 16'h0);
    steps(6);
    if (HN == 1) eq = '{8'hA5, 8'h3C};
    else         eq = '{8'h3C};
    chk_seq("ovf_drop");
    chk("ovf_rf", OVF, 2'b01);
    clrq();
    pulse(1, 0, 8'h44, 16'h0);
    steps(1 + HN);
    pulse(1, 0, 8'h55, 16'h0);
    steps(6);
    if (HN == 1) eq = '{8'hA5, 8'h44, 8'hA5, 8'h55};
    else         eq = '{8'h44, 8'h55};
    chk_seq("rel_accept");
    chk("ovf_rf_keep", OVF, 2'b01);
    chk("rel_rf_rdy", RF_RDY, 1);
    clrq();
    pulse(0, 1, 8'h0, 16'hAAAA);
    pulse(0, 1, 8'h0, 16'h5555);
    steps(8);
    if (HN == 1) eq = '{8'h5A, 8'hAA, 8'hAA};
    else         eq = '{8'hAA, 8'hAA};
    chk_seq("ovf_alu_drop");
    chk("ovf_both", OVF, 2'b11);

    // Reset during B0 of an ALU frame
    do_reset();
    pulse(0, 1, 8'h0, 16'h1234);
    steps(1 + HN);
    chk("mid_wr_pre", FIFO_WR, 1);
    RST = 1'b0;
    #1;
    chk("mid_wr", FIFO_WR, 0);
    chk("mid_tx", TX_DATA_OUT, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_rdy", {RF_RDY, ALU_RDY}, 2'b11);
    chk("mid_ovf", OVF, 0);
    step();
    RST = 1'b1;
    steps(10);
    chk("mid_nowr", wq.size(), 0);

    // Random traffic against the frame model
    do_reset();
    m_rf_p = 1'b0; m_alu_p = 1'b0; m_last = SRC_ALU; m_cur = SRC_ALU;
    m_rf_d = '0; m_alu_d = '0; m_ovf = '0;
    m_frame.delete();
    for (int k = 0; k < 3000; k++) begin
      RF_VALID  = ($urandom_range(3) == 0);
      ALU_VALID = ($urandom_range(3) == 0);
      RF_DATA   = 8'($urandom);
      ALU_DATA  = 16'($urandom);
      FIFO_FULL = ($urandom_range(3) == 0);
      @(negedge CLK);
      chk("rnd_wr", FIFO_WR, (m_frame.size() != 0) && !FIFO_FULL);
      chk("rnd_data", TX_DATA_OUT, (m_frame.size() != 0) ? m_frame[0] : 8'h00);
      chk("rnd_busy", BUSY, m_frame.size() != 0);
      chk("rnd_rdy", {RF_RDY, ALU_RDY}, {~m_rf_p, ~m_alu_p});
      chk("rnd_ovf", OVF, m_ovf);
      model_step();
      step();
    end
    RF_VALID = 1'b0; ALU_VALID = 1'b0; FIFO_FULL = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
